// File: rtl/result_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : result_bcd
//  Description : Sequential binary-to-BCD converter for the calculator
//                datapath. Converts the magnitude of an 18-bit sign-magnitude
//                product to packed BCD with shift-and-add-3, one bit per
//                clock, and derives a sign flag and a leading-zero blanking
//                mask for the 7-segment display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_bcd #(
    parameter int MAG_W  = 17,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MAG_W:0]        result,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int c_CNT_W  = $clog2(MAG_W + 1);
    localparam int c_BCD_W  = 4 * DIGITS;
    localparam int c_FULL_W = c_BCD_W + MAG_W;

    // Units digit is never blanked so a zero result still shows "0".
    localparam logic [DIGITS-1:0] c_BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                 r_state;
    logic [MAG_W-1:0]       r_bin;
    logic [c_BCD_W-1:0]     r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_sign;
    logic                   r_nonZero;

    logic [c_BCD_W-1:0]     w_adj;
    logic [c_FULL_W-1:0]    w_shifted;
    logic [DIGITS-1:0]      w_blank;

    // Per-digit add-3 correction applied before each shift.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                              : r_acc[4*i +: 4];
        end
    endgenerate

    // The combined accumulator/binary register shifted left by one bit.
    assign w_shifted = {w_adj, r_bin} << 1;

    // Digit i is blank when it and every more significant digit are zero.
    assign w_blank[0] = 1'b0;
    generate
        for (genvar i = 1; i < DIGITS; i++) begin : g_blank
            assign w_blank[i] = (r_acc[c_BCD_W-1:4*i] == '0);
        end
    endgenerate

    // Conversion FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_nonZero <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            neg       <= 1'b0;
            bcd       <= '0;
            blank     <= c_BLANK_RST;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bin     <= result[MAG_W-1:0];
                        r_sign    <= result[MAG_W];
                        r_nonZero <= (result[MAG_W-1:0] != '0);
                        r_acc     <= '0;
                        r_cnt     <= c_CNT_W'(MAG_W);
                        busy      <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_shifted[c_FULL_W-1:MAG_W];
                    r_bin <= w_shifted[MAG_W-1:0];
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    bcd     <= r_acc;
                    neg     <= r_sign & r_nonZero;
                    blank   <= w_blank;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_bcd
//  Description : Self-checking bench for result_bcd. A transaction-level
//                model (decimal digit extraction, latency countdown) is
//                compared with the DUT every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [17:0] result;
    logic        busy;
    logic        done;
    logic        neg;
    logic [23:0] bcd;
    logic [5:0]  blank;

    int checks = 0;
    int errors = 0;

    result_bcd #(.MAG_W(17), .DIGITS(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .result (result),
        .busy   (busy),
        .done   (done),
        .neg    (neg),
        .bcd    (bcd),
        .blank  (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal conversion by repeated division.
    function automatic logic [23:0] toBcd(input int unsigned m);
        logic [23:0] r;
        int unsigned v;
        r = '0;
        v = m;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Digit i is dark when the value is below 10^i.
    function automatic logic [5:0] blankOf(input int unsigned m);
        logic [5:0] b;
        int unsigned p;
        b = '0;
        p = 1;
        for (int i = 1; i < 6; i++) begin
            p = p * 10;
            b[i] = (m < p);
        end
        return b;
    endfunction

    // Reference model: idle/busy with an 18-edge completion countdown.
    logic        mValid = 1'b0;
    logic        mBusy, mDone, mNeg;
    logic [23:0] mBcd;
    logic [5:0]  mBlank;
    int          mRem;
    int unsigned mMag;
    logic        mSign;

    always @(posedge clk) begin
        if (rst) begin
            mValid = 1'b1;
            mBusy  = 1'b0;
            mDone  = 1'b0;
            mNeg   = 1'b0;
            mBcd   = '0;
            mBlank = 6'b111110;
            mRem   = 0;
        end else if (mValid) begin
            mDone = 1'b0;
            if (!mBusy) begin
                if (start) begin
                    mBusy = 1'b1;
                    mRem  = 18;
                    mMag  = int'(result[16:0]);
                    mSign = result[17];
                end
            end else begin
                mRem = mRem - 1;
                if (mRem == 0) begin
                    mBusy  = 1'b0;
                    mDone  = 1'b1;
                    mBcd   = toBcd(mMag);
                    mBlank = blankOf(mMag);
                    mNeg   = mSign && (mMag != 0);
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (mValid) begin
            checks++;
            if ({busy, done, neg, bcd, blank} !== {mBusy, mDone, mNeg, mBcd, mBlank}) begin
                errors++;
                $display("FAIL cycle-compare t=%0t got busy=%b done=%b neg=%b bcd=%h blank=%b want busy=%b done=%b neg=%b bcd=%h blank=%b",
                         $time, busy, done, neg, bcd, blank, mBusy, mDone, mNeg, mBcd, mBlank);
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    // Pulse start with a value and wait (bounded) for done; lat = edges after the accept edge.
    task automatic runConv(input logic [17:0] val, output int lat);
        logic got;
        @(negedge clk);
        result = val;
        start  = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            errors++;
            $display("FAIL timeout waiting for done got none want done");
        end
        lat = lat - 1;
    endtask

    int lat;
    int doneCnt;
    logic [23:0] capBcd;
    logic sawDone;
    int lastDone;
    int cyc;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        result = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset busy", 32'(busy), 32'd0);
        checkVal("reset bcd", 32'(bcd), 32'h0);
        checkVal("reset blank", 32'(blank), 32'b111110);
        @(negedge clk);
        rst = 1'b0;

        // Zero
        runConv(18'h00000, lat);
        checkVal("zero latency", 32'(lat), 32'd18);
        checkVal("zero bcd", 32'(bcd), 32'h000000);
        checkVal("zero neg", 32'(neg), 32'd0);
        checkVal("zero blank", 32'(blank), 32'b111110);

        // -255*255
        runConv({1'b1, 17'd65025}, lat);
        checkVal("65025 latency", 32'(lat), 32'd18);
        checkVal("65025 bcd", 32'(bcd), 32'h065025);
        checkVal("65025 neg", 32'(neg), 32'd1);
        checkVal("65025 blank", 32'(blank), 32'b100000);

        // Full scale
        runConv({1'b0, 17'd131071}, lat);
        checkVal("max bcd", 32'(bcd), 32'h131071);
        checkVal("max neg", 32'(neg), 32'd0);
        checkVal("max blank", 32'(blank), 32'b000000);

        // Negative zero
        runConv({1'b1, 17'd0}, lat);
        checkVal("negzero neg", 32'(neg), 32'd0);

        // Start while busy is ignored; input may change freely
        @(negedge clk);
        result = {1'b0, 17'd999};
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        doneCnt = 0;
        capBcd  = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            result = (k == 4) ? {1'b0, 17'd5} : 18'($urandom);
            start  = (k == 4);
            @(posedge clk);
            #1;
            if (done) begin
                doneCnt++;
                if (doneCnt == 1) capBcd = bcd;
            end
        end
        start = 1'b0;
        checkVal("busy-ignore done count", 32'(doneCnt), 32'd1);
        checkVal("busy-ignore bcd", 32'(capBcd), 32'h000999);
        checkVal("busy-ignore idle", 32'(busy), 32'd0);

        // Reset mid-conversion
        @(negedge clk);
        result = {1'b0, 17'd12345};
        start  = 1'b1;
        sawDone = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkVal("abort busy", 32'(busy), 32'd0);
        checkVal("abort bcd", 32'(bcd), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkVal("abort no done", 32'(sawDone), 32'd0);
        runConv({1'b0, 17'd42}, lat);
        checkVal("post-abort bcd", 32'(bcd), 32'h000042);
        checkVal("post-abort blank", 32'(blank), 32'b111100);

        // Continuous start with alternating operands
        @(negedge clk);
        result = {1'b0, 17'd7};
        start  = 1'b1;
        doneCnt  = 0;
        lastDone = 0;
        cyc      = 0;
        for (int k = 0; k < 100 && doneCnt < 4; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                doneCnt++;
                if (doneCnt > 1) checkVal("throughput period", 32'(cyc - lastDone), 32'd19);
                lastDone = cyc;
                if (doneCnt % 2 == 1) begin
                    checkVal("alt bcd 7", 32'(bcd), 32'h000007);
                    result = {1'b0, 17'd100000};
                end else begin
                    checkVal("alt bcd 100000", 32'(bcd), 32'h100000);
                    result = {1'b0, 17'd7};
                end
            end
        end
        checkVal("alt pulse count", 32'(doneCnt), 32'd4);
        @(negedge clk);
        start = 1'b0;
        repeat (22) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
